// File: rtl/click_decoder_pkg.sv
// click_decoder_pkg
//   Shared defaults and width helpers for the click decoder and its window
//   timer. State encodings stay local to click_decoder.
package click_decoder_pkg;

  localparam int DEF_WINDOW_CYCLES = 2_500_000;
  localparam int DEF_MAX_CLICKS    = 3;

  // Width of a counter that must hold 0..n-1; never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/click_window_timer.sv
// click_window_timer
//   Counts cycles inside an open click window and flags the last cycle of it.
//   The count saturates at WINDOW_CYCLES-1 and never wraps.
// Ports:
//   clk      in  clock, rising edge
//   reset    in  asynchronous, active-high reset
//   clear    in  restart the window (count <= 0); has priority over enable
//   enable   in  advance the count by one per cycle while not expired
//   expired  out count == WINDOW_CYCLES-1 (decoded from the count register)
module click_window_timer
  import click_decoder_pkg::*;
#(
  parameter int WINDOW_CYCLES = DEF_WINDOW_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int              TW   = cnt_w(WINDOW_CYCLES);
  localparam logic [TW-1:0]   LAST = TW'(WINDOW_CYCLES - 1);

  logic [TW-1:0] r_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else if (enable && !expired) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign expired = (r_count == LAST);

endmodule

// File: rtl/click_decoder.sv
// click_decoder
//   Groups single-cycle button pulses that arrive within WINDOW_CYCLES of each
//   other into one multi-click event (1..MAX_CLICKS). Reaching MAX_CLICKS
//   emits at once; otherwise the sequence closes when the window runs out.
// Ports:
//   clk           in  clock, rising edge
//   reset         in  asynchronous, active-high reset (drops any open sequence)
//   pulse         in  single-cycle click strobe
//   event_valid   out one-cycle strobe: a sequence has completed
//   event_clicks  out click count of the completed sequence (hold after strobe)
//   busy          out a sequence is open
module click_decoder
  import click_decoder_pkg::*;
#(
  parameter int WINDOW_CYCLES = DEF_WINDOW_CYCLES,
  parameter int MAX_CLICKS    = DEF_MAX_CLICKS,
  localparam int CLICK_W      = $clog2(MAX_CLICKS + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               pulse,
  output logic               event_valid,
  output logic [CLICK_W-1:0] event_clicks,
  output logic               busy
);

  typedef enum logic {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } state_t;

  localparam logic [CLICK_W-1:0] ONE_CLICK  = CLICK_W'(1);
  localparam logic [CLICK_W-1:0] MAX_C      = CLICK_W'(MAX_CLICKS);
  localparam logic [CLICK_W-1:0] LAST_OPEN  = CLICK_W'(MAX_CLICKS - 1);

  state_t             r_state;
  logic [CLICK_W-1:0] r_clicks;
  logic               r_event_valid;
  logic [CLICK_W-1:0] r_event_clicks;

  logic w_expired;
  logic w_timer_clear;
  logic w_timer_en;

  // Any pulse restarts the window; a timeout emit also rewinds it so the next
  // sequence starts from zero. A pulse on the expiry edge wins (inclusive
  // window), which falls out of clear having priority in the timer.
  assign w_timer_clear = pulse | ((r_state == COUNT) & w_expired);
  assign w_timer_en    = (r_state == COUNT);

  click_window_timer #(
    .WINDOW_CYCLES(WINDOW_CYCLES)
  ) u_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (w_timer_clear),
    .enable (w_timer_en),
    .expired(w_expired)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state        <= IDLE;
      r_clicks       <= '0;
      r_event_valid  <= 1'b0;
      r_event_clicks <= '0;
    end else begin
      r_event_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (pulse) begin
            r_state  <= COUNT;
            r_clicks <= ONE_CLICK;
          end
        end
        COUNT: begin
          if (pulse) begin
            if (r_clicks == LAST_OPEN) begin
              r_event_valid  <= 1'b1;
              r_event_clicks <= MAX_C;
              r_state        <= IDLE;
              r_clicks       <= '0;
            end else begin
              r_clicks <= r_clicks + 1'b1;
            end
          end else if (w_expired) begin
            r_event_valid  <= 1'b1;
            r_event_clicks <= r_clicks;
            r_state        <= IDLE;
            r_clicks       <= '0;
          end
        end
        default: begin
          r_state  <= IDLE;
          r_clicks <= '0;
        end
      endcase
    end
  end

  assign event_valid  = r_event_valid;
  assign event_clicks = r_event_clicks;
  assign busy         = (r_state == COUNT);

endmodule

// File: tb/tb_click_decoder.sv
module tb_click_decoder;

  localparam int W  = 8;
  localparam int M  = 3;
  localparam int CW = $clog2(M + 1);

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          pulse = 1'b0;
  logic          event_valid;
  logic [CW-1:0] event_clicks;
  logic          busy;

  click_decoder #(.WINDOW_CYCLES(W), .MAX_CLICKS(M)) dut (
    .clk         (clk),
    .reset       (reset),
    .pulse       (pulse),
    .event_valid (event_valid),
    .event_clicks(event_clicks),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Reference model: a sequence is "open" from its first pulse; it closes when
  // the count reaches M, or when no pulse has arrived for W edges since the
  // last counted one (a pulse exactly W edges later still counts).
  bit m_open;
  int m_cnt;
  int m_last;
  int m_n;
  bit m_ev;
  int m_clicks;

  function automatic void model_reset();
    m_open = 0; m_cnt = 0; m_last = 0; m_n = 0; m_ev = 0; m_clicks = 0;
  endfunction

  function automatic void model_edge(input bit p);
    m_ev = 0;
    if (m_open) begin
      if (p) begin
        if (m_cnt + 1 == M) begin
          m_ev = 1; m_clicks = M; m_open = 0; m_cnt = 0;
        end else begin
          m_cnt++; m_last = m_n;
        end
      end else if (m_n - m_last == W) begin
        m_ev = 1; m_clicks = m_cnt; m_open = 0; m_cnt = 0;
      end
    end else if (p) begin
      m_open = 1; m_cnt = 1; m_last = m_n;
    end
    m_n++;
  endfunction

  // One clock edge with pulse = p; outputs sampled 1 time unit after the edge.
  task automatic tick(input bit p);
    pulse = p;
    @(posedge clk);
    model_edge(p);
    #1;
    check("event_valid", event_valid, m_ev);
    check("event_clicks", event_clicks, m_clicks);
    check("busy", busy, m_open);
  endtask

  // Reset asserted mid-cycle (asynchronously) and held across two edges.
  task automatic async_reset();
    #3;
    pulse = 1'b0;
    reset = 1'b1;
    #1;
    model_reset();
    check("rst_event_valid", event_valid, 0);
    check("rst_event_clicks", event_clicks, 0);
    check("rst_busy", busy, 0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  typedef struct {
    string       name;
    logic [31:0] mask;     // bit i = pulse on edge i
    int          e1_edge;  // edge of first event
    int          e1_clk;
    int          e2_edge;  // edge of second event, -1 if none
    int          e2_clk;
    int          n_ev;
  } vec_t;

  vec_t vecs[8];

  initial begin
    vecs[0] = '{"single",        32'h0000_0001,  8, 1, -1, 0, 1};
    vecs[1] = '{"double",        32'h0000_0021, 13, 2, -1, 0, 1};
    vecs[2] = '{"triple_sat",    32'h0000_0015,  4, 3, -1, 0, 1};
    vecs[3] = '{"window_incl",   32'h0000_0101, 16, 2, -1, 0, 1};
    vecs[4] = '{"window_late",   32'h0000_0201,  8, 1, 17, 1, 2};
    vecs[5] = '{"sat_then_new",  32'h0000_0035,  4, 3, 13, 1, 2};
    vecs[6] = '{"consec3",       32'h0000_0007,  2, 3, -1, 0, 1};
    vecs[7] = '{"consec2",       32'h0000_0003,  9, 2, -1, 0, 1};

    model_reset();
    #2;
    async_reset();

    // Table-driven sequences, each from a clean reset.
    foreach (vecs[k]) begin
      int e1, c1, e2, c2, n;
      logic [31:0] mk;
      async_reset();
      mk = vecs[k].mask;
      e1 = -1; c1 = 0; e2 = -1; c2 = 0; n = 0;
      for (int i = 0; i < 40; i++) begin
        tick((i < 32) ? mk[i] : 1'b0);
        if (event_valid) begin
          n++;
          if (e1 < 0) begin e1 = i; c1 = event_clicks; end
          else if (e2 < 0) begin e2 = i; c2 = event_clicks; end
        end
      end
      check({vecs[k].name, "_e1_edge"}, e1, vecs[k].e1_edge);
      check({vecs[k].name, "_e1_clicks"}, c1, vecs[k].e1_clk);
      check({vecs[k].name, "_e2_edge"}, e2, vecs[k].e2_edge);
      check({vecs[k].name, "_e2_clicks"}, c2, vecs[k].e2_clk);
      check({vecs[k].name, "_n_events"}, n, vecs[k].n_ev);
    end

    // Reset mid-sequence: the partial sequence never produces an event.
    begin
      int n;
      async_reset();
      tick(1'b1); tick(1'b0); tick(1'b1); tick(1'b0);
      check("mid_busy_before_rst", busy, 1);
      async_reset();
      n = 0;
      for (int i = 0; i < 20; i++) begin
        tick(1'b0);
        if (event_valid) n++;
      end
      check("mid_no_event", n, 0);
      tick(1'b1);
      n = 0;
      for (int i = 0; i < W; i++) begin
        tick(1'b0);
        if (event_valid) begin n++; check("mid_after_clicks", event_clicks, 1); end
      end
      check("mid_after_event", n, 1);
      for (int i = 0; i < 4; i++) tick(1'b0);
      check("clicks_hold", event_clicks, 1);
      check("idle_busy", busy, 0);
    end

    // Randomized traffic against the model, with occasional async resets.
    async_reset();
    for (int i = 0; i < 4000; i++) begin
      int dens;
      dens = (i / 500) % 3;  // alternate sparse / medium / dense phases
      if ($urandom_range(0, 599) == 0) async_reset();
      case (dens)
        0:       tick($urandom_range(0, 11) == 0);
        1:       tick($urandom_range(0, 4) == 0);
        default: tick($urandom_range(0, 1) == 0);
      endcase
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
